// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: opcode/state enums and register-map helpers for the N-tap FIR controller.
package fir_ctrl_pkg;
    localparam int IDX_W = 3;
    typedef enum logic [2:0] {
        NOP = 3'd0, COPY = 3'd1, LOADONE = 3'd2, LOADTWO = 3'd3, ADD = 3'd4, SUB = 3'd5, MUL = 3'd6
    } op_t;
    typedef enum logic [3:0] {
        S_IDLE, S_STORE, S_ZERO, S_SHIFT, S_MUL, S_ACC, S_LOAD, S_LWAIT, S_ERR
    } state_t;
    function automatic int reg_new(input int n);
        return n + 1;
    endfunction
    // Coefficient register of tap 1; tap k lives at reg_coef(n) + k - 1.
    function automatic int reg_coef(input int n);
        return n + 2;
    endfunction
    function automatic int reg_tmp(input int n);
        return 2 * n + 2;
    endfunction
endpackage

// File: rtl/fir_tap_counter.sv
// fir_tap_counter: loadable up/down tap index with terminal flags for idx==N and idx==1.
module fir_tap_counter
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [IDX_W-1:0] idx,
    output logic             at_max,
    output logic             at_one
);
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) idx <= '0;
        else if (load) idx <= load_val;
        else if (inc) idx <= idx + IDX_W'(1);
        else if (dec) idx <= idx - IDX_W'(1);
    end
    assign at_max = idx == IDX_W'(NUM_TAPS);
    assign at_one = idx == IDX_W'(1);
endmodule

// File: rtl/fir_ctrl_param.sv
// fir_ctrl_param: sequencer for the shared regfile/ALU N-tap FIR datapath.
// Define FIR_CTRL_ERR_STICKY_EN to make err a sticky flag cleared by a full coefficient reload.
module fir_ctrl_param
    import fir_ctrl_pkg::*;
#(
    parameter int                  NUM_TAPS  = 4,
    parameter int                  REG_W     = 4,
    parameter logic [NUM_TAPS-1:0] SIGN_MASK = 4'b0101
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             dr,
    input  logic             lc,
    input  logic             overflow,
    output logic             cnt_up,
    output logic             clear,
    output logic             modwait,
    output op_t              op,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic             err
);
    localparam logic [REG_W-1:0] R_NEW  = REG_W'(reg_new(NUM_TAPS));
    localparam logic [REG_W-1:0] R_COEF = REG_W'(reg_coef(NUM_TAPS));
    localparam logic [REG_W-1:0] R_TMP  = REG_W'(reg_tmp(NUM_TAPS));
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             at_max, at_one, at_last, cnt_load, cnt_inc, cnt_dec;
    logic [REG_W-1:0] idx_r;
    logic [7:0]       mask;
    assign at_last  = idx == IDX_W'(NUM_TAPS - 1);
    assign idx_r    = REG_W'(idx);
    assign mask     = 8'(SIGN_MASK);
    assign cnt_load = state == S_ZERO || (lc && (state == S_IDLE || state == S_ERR));
    assign cnt_inc  = (state == S_SHIFT && !at_max) || (state == S_LOAD && !at_last);
    assign cnt_dec  = state == S_ACC && !overflow && !at_one;
    fir_tap_counter #(.NUM_TAPS(NUM_TAPS)) u_cnt (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (cnt_load),
        .load_val (IDX_W'(state == S_ZERO)),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .idx      (idx),
        .at_max   (at_max),
        .at_one   (at_one)
    );
    // modwait deliberately lags the state by one cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_IDLE;
            modwait <= 1'b0;
        end else begin
            modwait <= !(state inside {S_IDLE, S_LWAIT, S_ERR});
            case (state)
                S_IDLE:  state <= lc ? S_LOAD : (dr ? S_STORE : S_IDLE);
                S_STORE: state <= dr ? S_ZERO : S_ERR;
                S_ZERO:  state <= S_SHIFT;
                S_SHIFT: state <= at_max ? S_MUL : S_SHIFT;
                S_MUL:   state <= S_ACC;
                S_ACC:   state <= overflow ? S_ERR : (at_one ? S_IDLE : S_MUL);
                S_LOAD:  state <= at_last ? S_IDLE : S_LWAIT;
                S_LWAIT: state <= lc ? S_LOAD : S_LWAIT;
                S_ERR:   state <= lc ? S_LOAD : (dr ? S_STORE : S_ERR);
                default: state <= S_IDLE;
            endcase
        end
    end
    always_comb begin
        op     = NOP;
        src1   = '0;
        src2   = '0;
        dest   = '0;
        cnt_up = 1'b0;
        clear  = 1'b0;
        case (state)
            S_STORE: begin op = LOADONE; dest = R_NEW; end
            S_ZERO:  begin op = SUB; cnt_up = 1'b1; end
            S_SHIFT: begin op = COPY; src1 = idx_r + REG_W'(1); dest = idx_r; end
            S_MUL:   begin op = MUL; src1 = idx_r; src2 = R_NEW + idx_r; dest = R_TMP; end
            S_ACC:   begin op = mask[idx - IDX_W'(1)] ? SUB : ADD; src2 = R_TMP; end
            S_LOAD:  begin op = LOADTWO; dest = R_COEF + idx_r; clear = 1'b1; end
            default: ;
        endcase
    end
`ifdef FIR_CTRL_ERR_STICKY_EN
    logic err_q;
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) err_q <= 1'b0;
        else if ((state == S_STORE && !dr) || (state == S_ACC && overflow)) err_q <= 1'b1;
        else if (state == S_LOAD && at_last) err_q <= 1'b0;
    end
    assign err = err_q;
`else
    assign err = state == S_ERR;
`endif
endmodule

// File: tb/tb_fir_ctrl_param.sv
// tb_fir_ctrl_param: scoreboarded directed test of fir_ctrl_param at N=4, mask 0101.
// Expected err follows the FIR_CTRL_ERR_STICKY_EN build option.
module tb_fir_ctrl_param;
    import fir_ctrl_pkg::*;
    localparam int         N    = 4;
    localparam logic [3:0] MASK = 4'b0101;
    localparam int         TMP  = 2 * N + 2;
    typedef struct packed {
        logic [2:0] op;
        logic [3:0] s1, s2, d;
        logic       cu, cl, mw, er;
    } obs_t;
    logic       clk = 1'b0, n_reset = 1'b0, dr = 1'b0, lc = 1'b0, overflow = 1'b0;
    logic       cnt_up, clear, modwait, err;
    op_t        op;
    logic [3:0] src1, src2, dest;
    obs_t       sb[$];
    int         n_cmp = 0, n_bad = 0;
    logic       prev_busy = 1'b0;
`ifdef FIR_CTRL_ERR_STICKY_EN
    logic       sf = 1'b0;
`endif
    always #5 clk = ~clk;
    fir_ctrl_param #(.NUM_TAPS(N), .REG_W(4), .SIGN_MASK(MASK)) dut (
        .clk(clk), .n_reset(n_reset), .dr(dr), .lc(lc), .overflow(overflow),
        .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
        .src1(src1), .src2(src2), .dest(dest), .err(err)
    );
    function automatic obs_t observe();
        obs_t g;
        g = '{op: op, s1: src1, s2: src2, d: dest, cu: cnt_up, cl: clear, mw: modwait, er: err};
        return g;
    endfunction
    task automatic check(input obs_t g, input obs_t e, input string tag);
        n_cmp++;
        assert (g === e) else begin
            n_bad++;
            $error("FAIL %s: got op=%0d s1=%0d s2=%0d d=%0d cu=%b cl=%b mw=%b err=%b expected op=%0d s1=%0d s2=%0d d=%0d cu=%b cl=%b mw=%b err=%b",
                   tag, g.op, g.s1, g.s2, g.d, g.cu, g.cl, g.mw, g.er, e.op, e.s1, e.s2, e.d, e.cu, e.cl, e.mw, e.er);
        end
    endtask
    // Expect the given outputs in the current state, then apply inputs for the next edge.
    task automatic step(input logic d, input logic l, input logic o, input logic [2:0] eop,
                        input int es1, input int es2, input int ed, input logic ecu,
                        input logic ecl, input logic in_err, input string tag);
        obs_t e;
        e = '{op: eop, s1: 4'(es1), s2: 4'(es2), d: 4'(ed), cu: ecu, cl: ecl, mw: prev_busy, er: in_err};
`ifdef FIR_CTRL_ERR_STICKY_EN
        if (in_err) sf = 1'b1;
        e.er = sf;
`endif
        sb.push_back(e);
        @(negedge clk);
        check(observe(), sb.pop_front(), tag);
        prev_busy = eop != NOP;
`ifdef FIR_CTRL_ERR_STICKY_EN
        if (eop == LOADTWO && ed == 2 * N + 1) sf = 1'b0;
`endif
        dr = d;
        lc = l;
        overflow = o;
    endtask
    // From STORE (dr still high) through the last ACC; ov_at = ACC ordinal that overflows.
    task automatic run_sample(input int ov_at);
        step(1, 0, 0, LOADONE, 0, 0, N + 1, 0, 0, 0, "store");
        step(0, 0, 0, SUB, 0, 0, 0, 1, 0, 0, "zero");
        for (int i = 1; i <= N; i++) step(0, 0, 0, COPY, i + 1, 0, i, 0, 0, 0, "shift");
        for (int k = N; k >= 1; k--) begin
            step(0, 0, 0, MUL, k, N + 1 + k, TMP, 0, 0, 0, "mul");
            step(0, 0, logic'(N - k + 1 == ov_at), ((int'(MASK) >> (k - 1)) & 1) != 0 ? SUB : ADD,
                 0, TMP, 0, 0, 0, 0, "acc");
            if (N - k + 1 == ov_at) return;
        end
    endtask
    // From the first LOAD through the final one, lc pulses separated by an idle cycle.
    task automatic run_load();
        step(0, 0, 0, LOADTWO, 0, 0, N + 2, 0, 1, 0, "load");
        for (int k = 1; k < N; k++) begin
            step(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "lwait");
            step(0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, "lwait_lc");
            step(0, 0, 0, LOADTWO, 0, 0, N + 2 + k, 0, 1, 0, "load");
        end
    endtask
    initial begin
        @(negedge clk);
        check(observe(), obs_t'(0), "reset");
        n_reset = 1'b1;
        step(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle");
        step(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_prio");
        run_load();
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_dr");
        run_sample(0);
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_proto");
        step(0, 0, 0, LOADONE, 0, 0, N + 1, 0, 0, 0, "store_drop");
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 1, "err_proto");
        run_sample(0);
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_ovf");
        run_sample(2);
        step(0, 0, 0, NOP, 0, 0, 0, 0, 0, 1, "err_ovf");
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 1, "err_hold");
        run_sample(0);
        step(0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_reload");
        run_load();
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_clean");
        step(1, 0, 0, LOADONE, 0, 0, N + 1, 0, 0, 0, "store");
        step(0, 0, 0, SUB, 0, 0, 0, 1, 0, 0, "zero");
        for (int i = 1; i <= N; i++) step(0, 0, 0, COPY, i + 1, 0, i, 0, 0, 0, "shift");
        step(0, 0, 0, MUL, N, 2 * N + 1, TMP, 0, 0, 0, "mul_pre_reset");
        n_reset = 1'b0;
        #1;
        check(observe(), obs_t'(0), "async_reset");
        @(negedge clk);
        n_reset = 1'b1;
        prev_busy = 1'b0;
`ifdef FIR_CTRL_ERR_STICKY_EN
        sf = 1'b0;
`endif
        step(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_after_reset");
        run_sample(0);
        step(0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, "idle_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
